// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: retirement monitor for the single-cycle cpu.
// While capturing, each retired cycle becomes one trace record. The record is
// classified as halt, reg-write or load, store, or nop/branch, and is stamped
// into the cycle and instruction counters. Records go into a circular buffer
// that is drained through a registered valid/enable read port.
//
// Ports:
//   clk, rst            clock (rising edge); synchronous active-high reset
//   en                  start capture (level, sampled in IDLE)
//   pc .. halt          retirement signals from the cpu
//   rd_en               pop request
//   rd_valid, rd_data   popped record {kind, is_load, reg, pc, value, addr}, one cycle after rd_en
//   count, empty, full  buffer occupancy
//   overflow            sticky: a record was dropped (WRAP=0) or overwritten (WRAP=1)
//   halted, timeout     terminal capture states
//   cycle_count         RUN cycles elapsed, saturating at CYCLE_LIMIT
//   inst_count          records generated, including dropped ones
module retire_trace_buffer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned REG_W       = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WRAP        = 0,
  parameter int unsigned CYCLE_LIMIT = 100000,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned REC_W      = 2 + 1 + REG_W + 2 * ADDR_W + DATA_W,
  localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              reg_write,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              halt,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [REC_W-1:0]  rd_data,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(CYCLE_LIMIT);
  localparam logic [PTR_W:0]   Depth = (PTR_W + 1)'(DEPTH);
  localparam bit               WrapEn = (WRAP != 0);

  typedef enum logic [1:0] {StIdle, StRun, StHalted, StTimeout} state_e;

  state_e             r_state, w_state_next;
  logic [REC_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [PTR_W:0]     r_count, w_count_next;
  logic               r_overflow, r_rd_valid;
  logic [REC_W-1:0]   r_rd_data;
  logic [CNT_W-1:0]   r_cycle_count, r_inst_count, w_cycle_inc;

  logic [1:0]         w_kind;
  logic               w_is_load;
  logic [REG_W-1:0]   w_reg;
  logic [DATA_W-1:0]  w_value;
  logic [ADDR_W-1:0]  w_addr;
  logic [REC_W-1:0]   w_rec;
  logic               w_capture, w_pop, w_full, w_write, w_overwrite, w_drop;

  assign w_cycle_inc = r_cycle_count + CNT_W'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (en) w_state_next = StRun;
      // Halt wins over the watchdog when both land on the same record.
      StRun: begin
        if (halt) w_state_next = StHalted;
        else if (w_cycle_inc >= Limit) w_state_next = StTimeout;
      end
      default: w_state_next = r_state;
    endcase
  end

  // Record classification, highest priority first.
  always_comb begin
    w_kind    = 2'd0;
    w_is_load = 1'b0;
    w_reg     = '0;
    w_value   = '0;
    w_addr    = '0;
    if (halt) begin
      w_kind = 2'd3;
    end else if (reg_write) begin
      w_kind  = 2'd1;
      w_reg   = write_reg;
      w_value = write_data;
      if (mem_read) begin
        w_is_load = 1'b1;
        w_addr    = mem_addr;
      end
    end else if (mem_write) begin
      w_kind  = 2'd2;
      w_value = mem_data;
      w_addr  = mem_addr;
    end
  end

  assign w_rec = {w_kind, w_is_load, w_reg, pc, w_value, w_addr};

  // A simultaneous pop frees a slot, so a push into a full buffer is a plain push.
  assign w_capture   = (r_state == StRun);
  assign w_pop       = rd_en && (r_count != '0);
  assign w_full      = (r_count == Depth);
  assign w_write     = w_capture && (!w_full || w_pop || WrapEn);
  assign w_overwrite = w_capture && w_full && !w_pop && WrapEn;
  assign w_drop      = w_capture && w_full && !w_pop && !WrapEn;

  always_comb begin
    w_count_next = r_count;
    if (w_write && !w_overwrite && !w_pop) w_count_next = r_count + (PTR_W + 1)'(1);
    else if (w_pop && !w_write)            w_count_next = r_count - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_cycle_count <= '0;
      r_inst_count  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_rd_valid <= w_pop;
      if (w_capture) begin
        r_inst_count <= r_inst_count + CNT_W'(1);
        if (r_cycle_count < Limit) r_cycle_count <= w_cycle_inc;
      end
      if (w_write) r_wptr <= r_wptr + PTR_W'(1);
      // Overwrite discards the oldest entry, so the read side skips past it.
      if (w_pop || w_overwrite) r_rptr <= r_rptr + PTR_W'(1);
      if (w_overwrite || w_drop) r_overflow <= 1'b1;
      if (w_pop) r_rd_data <= r_mem[r_rptr];
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wptr] <= w_rec;
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = w_full;
  assign overflow    = r_overflow;
  assign halted      = (r_state == StHalted);
  assign timeout     = (r_state == StTimeout);
  assign cycle_count = r_cycle_count;
  assign inst_count  = r_inst_count;

endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;

  localparam int RW = 2 + 1 + 4 + 2 * 16 + 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] pc = '0;
  logic        reg_write = 1'b0;
  logic [3:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data = '0;
  logic        halt = 1'b0;
  logic        rd_en = 1'b0;

  // u_b: DEPTH 16, stop-on-full; u_s0: DEPTH 4, stop-on-full, limit 10; u_s1: DEPTH 4, wrap
  logic          rd_valid_b, empty_b, full_b, overflow_b, halted_b, timeout_b;
  logic [RW-1:0] rd_data_b;
  logic [4:0]    count_b;
  logic [31:0]   cyc_b, inst_b;
  logic          rd_valid_s0, empty_s0, full_s0, overflow_s0, halted_s0, timeout_s0;
  logic [RW-1:0] rd_data_s0;
  logic [2:0]    count_s0;
  logic [31:0]   cyc_s0, inst_s0;
  logic          rd_valid_s1, empty_s1, full_s1, overflow_s1, halted_s1, timeout_s1;
  logic [RW-1:0] rd_data_s1;
  logic [2:0]    count_s1;
  logic [31:0]   cyc_s1, inst_s1;

  retire_trace_buffer #(.DEPTH(16), .WRAP(0), .CYCLE_LIMIT(100000)) u_b (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt), .rd_en(rd_en), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .count(count_b), .empty(empty_b), .full(full_b), .overflow(overflow_b), .halted(halted_b),
    .timeout(timeout_b), .cycle_count(cyc_b), .inst_count(inst_b));

  retire_trace_buffer #(.DEPTH(4), .WRAP(0), .CYCLE_LIMIT(10)) u_s0 (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt), .rd_en(rd_en), .rd_valid(rd_valid_s0),
    .rd_data(rd_data_s0), .count(count_s0), .empty(empty_s0), .full(full_s0),
    .overflow(overflow_s0), .halted(halted_s0), .timeout(timeout_s0), .cycle_count(cyc_s0),
    .inst_count(inst_s0));

  retire_trace_buffer #(.DEPTH(4), .WRAP(1), .CYCLE_LIMIT(10)) u_s1 (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt), .rd_en(rd_en), .rd_valid(rd_valid_s1),
    .rd_data(rd_data_s1), .count(count_s1), .empty(empty_s1), .full(full_s1),
    .overflow(overflow_s1), .halted(halted_s1), .timeout(timeout_s1), .cycle_count(cyc_s1),
    .inst_count(inst_s1));

  always #5 clk = ~clk;

  // Instance under observation for the current scenario.
  int            sel = 0;
  logic          obs_valid, obs_empty, obs_full, obs_ovf, obs_halted, obs_timeout;
  logic [RW-1:0] obs_data;
  logic [4:0]    obs_count;
  logic [31:0]   obs_cyc, obs_inst;

  always_comb begin
    obs_valid = rd_valid_b; obs_data = rd_data_b; obs_count = count_b; obs_empty = empty_b;
    obs_full = full_b; obs_ovf = overflow_b; obs_halted = halted_b; obs_timeout = timeout_b;
    obs_cyc = cyc_b; obs_inst = inst_b;
    if (sel == 1) begin
      obs_valid = rd_valid_s0; obs_data = rd_data_s0; obs_count = {2'b00, count_s0};
      obs_empty = empty_s0; obs_full = full_s0; obs_ovf = overflow_s0; obs_halted = halted_s0;
      obs_timeout = timeout_s0; obs_cyc = cyc_s0; obs_inst = inst_s0;
    end else if (sel == 2) begin
      obs_valid = rd_valid_s1; obs_data = rd_data_s1; obs_count = {2'b00, count_s1};
      obs_empty = empty_s1; obs_full = full_s1; obs_ovf = overflow_s1; obs_halted = halted_s1;
      obs_timeout = timeout_s1; obs_cyc = cyc_s1; obs_inst = inst_s1;
    end
  end

  int            n_vec = 0;
  int            n_err = 0;
  logic [RW-1:0] q_exp [$];
  logic [RW-1:0] exp_rec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (obs_valid) begin
      n_vec++;
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL rd_data: got %h, expected no rd_valid", obs_data);
      end else begin
        exp_rec = q_exp.pop_front();
        if (obs_data !== exp_rec) begin
          n_err++;
          $display("FAIL rd_data: got %h, expected %h", obs_data, exp_rec);
        end
      end
    end
  end

  function automatic logic [RW-1:0] rec(input logic [1:0] k, input logic l, input logic [3:0] r,
                                        input logic [15:0] p, input logic [15:0] v,
                                        input logic [15:0] a);
    return {k, l, r, p, v, a};
  endfunction

  typedef struct {
    logic        rw;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic        mr;
    logic        mw;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic [15:0] pcv;
    logic        hlt;
    logic [1:0]  kind;
    logic        isl;
    logic [3:0]  rf;
    logic [15:0] value;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl [6];

  task automatic idle_in();
    reg_write = 1'b0; write_reg = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_data = '0; halt = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    reg_write = v.rw; write_reg = v.wreg; write_data = v.wdata; mem_read = v.mr;
    mem_write = v.mw; mem_addr = v.maddr; mem_data = v.mdata; pc = v.pcv; halt = v.hlt;
  endtask

  // Junk on the unused fields makes sure classification masks them.
  task automatic nop_in(input logic [15:0] p, input logic h);
    idle_in();
    write_reg = 4'hE; write_data = 16'hA5A5; mem_addr = 16'h5A5A; mem_data = 16'h3C3C;
    pc = p; halt = h;
  endtask

  task automatic reset_all(input int s);
    sel = s; rst = 1'b1; en = 1'b0; rd_en = 1'b0; idle_in(); q_exp.delete();
    @(negedge clk);
    chk("reset rd_valid", 64'(obs_valid), 64'd0);
    chk("reset count", 64'(obs_count), 64'd0);
    chk("reset empty", 64'(obs_empty), 64'd1);
    chk("reset flags", 64'({obs_full, obs_ovf, obs_halted, obs_timeout}), 64'd0);
    chk("reset counters", 64'({obs_cyc, obs_inst}), 64'd0);
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int n, input string tag);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " rd_valid"}, 64'(obs_valid), 64'd1);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{rw:1'b1, wreg:4'd3, wdata:16'h00AA, mr:1'b0, mw:1'b0, maddr:16'h5555,
               mdata:16'h0000, pcv:16'h0000, hlt:1'b0,
               kind:2'd1, isl:1'b0, rf:4'd3, value:16'h00AA, addr:16'h0000};
    tbl[1] = '{rw:1'b0, wreg:4'd7, wdata:16'h9999, mr:1'b0, mw:1'b1, maddr:16'h0010,
               mdata:16'h1234, pcv:16'h0002, hlt:1'b0,
               kind:2'd2, isl:1'b0, rf:4'd0, value:16'h1234, addr:16'h0010};
    tbl[2] = '{rw:1'b0, wreg:4'd2, wdata:16'h4444, mr:1'b0, mw:1'b0, maddr:16'h0044,
               mdata:16'h3333, pcv:16'h0004, hlt:1'b0,
               kind:2'd0, isl:1'b0, rf:4'd0, value:16'h0000, addr:16'h0000};
    tbl[3] = '{rw:1'b1, wreg:4'd5, wdata:16'hBEEF, mr:1'b1, mw:1'b0, maddr:16'h0020,
               mdata:16'h0000, pcv:16'h0006, hlt:1'b0,
               kind:2'd1, isl:1'b1, rf:4'd5, value:16'hBEEF, addr:16'h0020};
    tbl[4] = '{rw:1'b1, wreg:4'd6, wdata:16'h0C0C, mr:1'b0, mw:1'b1, maddr:16'h0030,
               mdata:16'hD00D, pcv:16'h0008, hlt:1'b0,
               kind:2'd1, isl:1'b0, rf:4'd6, value:16'h0C0C, addr:16'h0000};
    tbl[5] = '{rw:1'b1, wreg:4'd9, wdata:16'h7777, mr:1'b1, mw:1'b1, maddr:16'h0040,
               mdata:16'h8888, pcv:16'h000A, hlt:1'b1,
               kind:2'd3, isl:1'b0, rf:4'd0, value:16'h0000, addr:16'h0000};

    // Classification table, halt, freeze, single and back-to-back drain.
    reset_all(0);
    chk("idle->run cycle_count", 64'(obs_cyc), 64'd0);
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i]);
      q_exp.push_back(rec(tbl[i].kind, tbl[i].isl, tbl[i].rf, tbl[i].pcv, tbl[i].value,
                          tbl[i].addr));
      @(negedge clk);
      if (i == 2) begin
        chk("3 rec count", 64'(obs_count), 64'd3);
        chk("3 rec inst_count", 64'(obs_inst), 64'd3);
        chk("3 rec cycle_count", 64'(obs_cyc), 64'd3);
      end
    end
    chk("halt halted", 64'(obs_halted), 64'd1);
    chk("halt count", 64'(obs_count), 64'd6);
    idle_in();
    repeat (3) @(negedge clk);
    chk("halted frozen inst", 64'(obs_inst), 64'd6);
    chk("halted frozen cycle", 64'(obs_cyc), 64'd6);
    chk("halted no capture", 64'(obs_count), 64'd6);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("single pop rd_valid", 64'(obs_valid), 64'd1);
    chk("single pop count", 64'(obs_count), 64'd5);
    @(negedge clk);
    chk("rd_valid pulse", 64'(obs_valid), 64'd0);
    drain(5, "b2b");
    chk("drained count", 64'(obs_count), 64'd0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("pop empty rd_valid", 64'(obs_valid), 64'd0);
    chk("pop empty count", 64'(obs_count), 64'd0);
    chk("pop empty empty", 64'(obs_empty), 64'd1);
    #1 chk("scoreboard drained 1", 64'(q_exp.size()), 64'd0);

    // Stop-on-full: 6 records into depth 4, the 6th being the halt.
    reset_all(1);
    for (int i = 0; i < 6; i++) begin
      nop_in(16'h0100 + 16'(4 * i), i == 5);
      if (i < 4) q_exp.push_back(rec(2'd0, 1'b0, 4'd0, 16'h0100 + 16'(4 * i), 16'h0, 16'h0));
      @(negedge clk);
    end
    idle_in();
    chk("wrap0 count", 64'(obs_count), 64'd4);
    chk("wrap0 full", 64'(obs_full), 64'd1);
    chk("wrap0 overflow", 64'(obs_ovf), 64'd1);
    chk("wrap0 inst_count", 64'(obs_inst), 64'd6);
    drain(4, "wrap0");
    #1 chk("scoreboard drained 2", 64'(q_exp.size()), 64'd0);

    // Overwrite-oldest: records 3..6 survive.
    reset_all(2);
    for (int i = 0; i < 6; i++) begin
      nop_in(16'h0200 + 16'(4 * i), i == 5);
      if (i >= 2) q_exp.push_back(rec((i == 5) ? 2'd3 : 2'd0, 1'b0, 4'd0,
                                      16'h0200 + 16'(4 * i), 16'h0, 16'h0));
      @(negedge clk);
    end
    idle_in();
    chk("wrap1 count", 64'(obs_count), 64'd4);
    chk("wrap1 overflow", 64'(obs_ovf), 64'd1);
    chk("wrap1 inst_count", 64'(obs_inst), 64'd6);
    drain(4, "wrap1");
    #1 chk("scoreboard drained 3", 64'(q_exp.size()), 64'd0);

    // Full buffer with push and pop in the same cycle.
    reset_all(1);
    for (int i = 0; i < 6; i++) begin
      nop_in(16'h0300 + 16'(4 * i), i == 5);
      rd_en = (i >= 4);
      q_exp.push_back(rec((i == 5) ? 2'd3 : 2'd0, 1'b0, 4'd0, 16'h0300 + 16'(4 * i),
                          16'h0, 16'h0));
      @(negedge clk);
      if (i == 3) chk("pp full", 64'(obs_full), 64'd1);
      if (i >= 4) begin
        chk("pp count", 64'(obs_count), 64'd4);
        chk("pp overflow", 64'(obs_ovf), 64'd0);
      end
    end
    rd_en = 1'b0;
    idle_in();
    drain(4, "pp");
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("pp empty rd_valid", 64'(obs_valid), 64'd0);
    chk("pp empty count", 64'(obs_count), 64'd0);
    #1 chk("scoreboard drained 4", 64'(q_exp.size()), 64'd0);

    // Watchdog after 10 RUN cycles.
    reset_all(1);
    for (int i = 0; i < 10; i++) begin
      nop_in(16'h0400 + 16'(4 * i), 1'b0);
      if (i < 4) q_exp.push_back(rec(2'd0, 1'b0, 4'd0, 16'h0400 + 16'(4 * i), 16'h0, 16'h0));
      @(negedge clk);
      if (i == 8) chk("pre-timeout", 64'(obs_timeout), 64'd0);
    end
    idle_in();
    chk("timeout flag", 64'(obs_timeout), 64'd1);
    chk("timeout cycle_count", 64'(obs_cyc), 64'd10);
    chk("timeout inst_count", 64'(obs_inst), 64'd10);
    chk("timeout not halted", 64'(obs_halted), 64'd0);
    repeat (3) @(negedge clk);
    chk("timeout frozen", 64'({obs_cyc, obs_inst}), {32'd10, 32'd10});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("timeout no refill", 64'(obs_count), 64'd3);
    drain(3, "timeout");
    #1 chk("scoreboard drained 5", 64'(q_exp.size()), 64'd0);

    // Reset in the middle of RUN with a pop in flight.
    reset_all(0);
    for (int i = 0; i < 3; i++) begin
      nop_in(16'h0500 + 16'(4 * i), 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    rd_en = 1'b1;
    q_exp.delete();
    @(negedge clk);
    chk("midrst rd_valid", 64'(obs_valid), 64'd0);
    chk("midrst count", 64'(obs_count), 64'd0);
    chk("midrst empty", 64'(obs_empty), 64'd1);
    chk("midrst counters", 64'({obs_cyc, obs_inst}), 64'd0);
    chk("midrst rd_data", 64'(obs_data), 64'd0);
    rst = 1'b0;
    rd_en = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst idle cycle_count", 64'(obs_cyc), 64'd0);
    chk("midrst idle count", 64'(obs_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
